// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the data-memory load/store initiator.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addrLo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addrLo;
      SZ_HALF: be = addrLo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Reserved size is folded into misalignment so it never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] wData);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wData[7:0]}};
      SZ_HALF: rep = {2{wData[15:0]}};
      default: rep = wData;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a memory read word and sign/zero-extends it.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] MDataIn,
  input  logic [1:0]  Size,
  input  logic [1:0]  AddrLo,
  input  logic        Sext,
  output logic [31:0] Result
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = MDataIn[7:0];
    case (AddrLo)
      2'd0: byteLane = MDataIn[7:0];
      2'd1: byteLane = MDataIn[15:8];
      2'd2: byteLane = MDataIn[23:16];
      2'd3: byteLane = MDataIn[31:24];
      default: byteLane = MDataIn[7:0];
    endcase
    halfLane = AddrLo[1] ? MDataIn[31:16] : MDataIn[15:0];

    case (Size)
      SZ_BYTE: Result = {{24{Sext & byteLane[7]}}, byteLane};
      SZ_HALF: Result = {{16{Sext & halfLane[15]}}, halfLane};
      default: Result = MDataIn;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// One-at-a-time load/store initiator: turns a CPU request into a single
// data-memory bus transaction and reports completion, misalignment and timeout.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Sext,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        AddrErr,
  output logic        TimeoutErr,
  output logic        CS,
  output logic        RW,
  output logic [3:0]  BE,
  output logic [29:0] MAddr,
  output logic [31:0] MDataOut,
  input  logic [31:0] MDataIn,
  input  logic        DataReady,
  output state_t      DbgState
);

  // Handshake: Req is taken only while Busy=0; every accepted request ends
  // with exactly one Done pulse carrying RData/AddrErr/TimeoutErr.

  state_t      state, nextState;
  logic        wrQ, sextQ;
  logic [1:0]  sizeQ, addrLoQ;
  logic [7:0]  waitCnt;
  logic        addrErrQ, timeoutErrQ;
  logic [31:0] alignedData;
  logic        reqBad;

  assign reqBad = is_misaligned(Size, Addr[1:0]);

  load_align uAlign (
    .MDataIn (MDataIn),
    .Size    (sizeQ),
    .AddrLo  (addrLoQ),
    .Sext    (sextQ),
    .Result  (alignedData)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (Req) nextState = reqBad ? ST_RESP : ST_ISSUE;
      ST_ISSUE: nextState = ST_WAIT;
      ST_WAIT:  if (DataReady || (waitCnt == TIMEOUT)) nextState = ST_RESP;
      ST_RESP:  nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wrQ         <= 1'b0;
      sextQ       <= 1'b0;
      sizeQ       <= 2'b00;
      addrLoQ     <= 2'b00;
      MAddr       <= 30'd0;
      BE          <= 4'b0000;
      MDataOut    <= 32'd0;
      RData       <= 32'd0;
      waitCnt     <= 8'd0;
      addrErrQ    <= 1'b0;
      timeoutErrQ <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req) begin
            timeoutErrQ <= 1'b0;
            if (reqBad) begin
              addrErrQ <= 1'b1;
            end else begin
              addrErrQ <= 1'b0;
              wrQ      <= Wr;
              sextQ    <= Sext;
              sizeQ    <= Size;
              addrLoQ  <= Addr[1:0];
              MAddr    <= Addr[31:2];
              BE       <= be_gen(Size, Addr[1:0]);
              MDataOut <= store_rep(Size, WData);
              waitCnt  <= 8'd0;
            end
          end
        end
        ST_WAIT: begin
          // A response arriving on the last permitted cycle still wins.
          if (DataReady) begin
            if (!wrQ) RData <= alignedData;
          end else if (waitCnt == TIMEOUT) begin
            timeoutErrQ <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        ST_RESP: begin
          addrErrQ    <= 1'b0;
          timeoutErrQ <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Busy       = (state != ST_IDLE);
  assign Done       = (state == ST_RESP);
  assign CS         = (state == ST_ISSUE);
  assign RW         = CS & wrQ;
  assign AddrErr    = Done & addrErrQ;
  assign TimeoutErr = Done & timeoutErrQ;
  assign DbgState   = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, wr = 1'b0, sext = 1'b0, data_ready = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0, mdata_in = 32'd0;
  logic        busy, done, addr_err, timeout_err, cs, rw;
  logic [31:0] rdata, mdata_out;
  logic [3:0]  be;
  logic [29:0] maddr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // model state for the transaction in flight
  bit          active = 1'b0;
  int          cyc = 0;
  logic        t_wr, t_sext, t_bad, t_timeout;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata, t_mdin;
  int          t_done;
  logic [31:0] exp_rdata = 32'd0;

  // observed snapshots for literal checks
  int          snap_done_cyc;
  int          snap_cs_count;
  logic [3:0]  snap_be;
  logic [29:0] snap_maddr;
  logic [31:0] snap_mdo;
  logic        snap_rw;
  logic        snap_aerr, snap_terr;

  mem_access_ctrl #(.TIMEOUT(8'(TO))) dut (
    .Clk(clk), .Reset_n(rst_n), .Req(req), .Wr(wr), .Size(size), .Sext(sext),
    .Addr(addr), .WData(wdata), .Busy(busy), .Done(done), .RData(rdata),
    .AddrErr(addr_err), .TimeoutErr(timeout_err), .CS(cs), .RW(rw), .BE(be),
    .MAddr(maddr), .MDataOut(mdata_out), .MDataIn(mdata_in),
    .DataReady(data_ready), .DbgState(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [1:0] a);
    if (s == 2'd0) return 4'b0001 << a;
    if (s == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_store(input logic [1:0] s, input logic [31:0] w);
    if (s == 2'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    if (s == 2'd1) return {w[15:0], w[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic sx,
                                         input logic [1:0] a, input logic [31:0] m);
    logic [31:0] v;
    if (s == 2'd2) return m;
    if (s == 2'd0) begin
      v = (m >> (8 * a)) & 32'h0000_00FF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (m >> (16 * a[1])) & 32'h0000_FFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // scoreboard: one compare per output per cycle, sampled mid-cycle
  always @(negedge clk) begin
    logic e_busy, e_done, e_cs, e_ae, e_te, e_hold;
    if (!rst_n) begin
      exp_rdata = 32'd0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cs", cs, 0);
      check("rst_rw", rw, 0);
      check("rst_aerr", addr_err, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_be", be, 0);
      check("rst_maddr", maddr, 0);
      check("rst_mdo", mdata_out, 0);
      check("rst_rdata", rdata, 0);
    end else begin
      e_busy = 0; e_done = 0; e_cs = 0; e_ae = 0; e_te = 0; e_hold = 0;
      if (active) begin
        e_busy = (cyc >= 1) && (cyc <= t_done);
        e_done = (cyc == t_done);
        e_cs   = !t_bad && (cyc == 1);
        e_ae   = e_done && t_bad;
        e_te   = e_done && t_timeout;
        e_hold = !t_bad && (cyc >= 1) && (cyc < t_done);
        if (e_done && !t_bad && !t_timeout && !t_wr)
          exp_rdata = m_load(t_size, t_sext, t_addr[1:0], t_mdin);
      end
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("cs", cs, e_cs);
      check("rw", rw, e_cs & t_wr);
      check("addr_err", addr_err, e_ae);
      check("timeout_err", timeout_err, e_te);
      check("rdata", rdata, exp_rdata);
      if (e_hold) begin
        check("be", be, m_be(t_size, t_addr[1:0]));
        check("maddr", maddr, t_addr[31:2]);
        check("mdata_out", mdata_out, m_store(t_size, t_wdata));
      end
      if (done) begin
        snap_done_cyc = cyc;
        snap_aerr = addr_err;
        snap_terr = timeout_err;
      end
      if (cs) begin
        snap_cs_count++;
        snap_be = be; snap_maddr = maddr; snap_mdo = mdata_out; snap_rw = rw;
      end
    end
  end

  // driver: d = WAIT cycles with DataReady low before it rises (large = never)
  task automatic run_txn(input logic w, input logic [1:0] s, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] md, input int d,
                         input bit req_in_resp, input int abort_at);
    @(posedge clk); #1;
    t_wr = w; t_size = s; t_sext = sx; t_addr = a; t_wdata = wd; t_mdin = md;
    t_bad = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    t_timeout = !t_bad && (d > TO);
    t_done = t_bad ? 1 : 3 + ((d > TO) ? TO : d);
    snap_done_cyc = -1; snap_cs_count = 0;
    wr = w; size = s; sext = sx; addr = a; wdata = wd; mdata_in = md;
    req = 1'b1; cyc = 0; active = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; cyc = 1;
    while (cyc <= t_done) begin
      data_ready = !t_bad && (cyc == 2 + d);
      req = req_in_resp && (cyc == t_done);
      if (abort_at > 0 && cyc == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort_cs", cs, 0);
        check("abort_busy", busy, 0);
        active = 1'b0; data_ready = 1'b0; req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    data_ready = 1'b0; req = 1'b0;
    @(negedge clk);
    active = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // word store
    run_txn(1, 2'd2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    check("st_word_be", snap_be, 4'b1111);
    check("st_word_maddr", snap_maddr, 30'h4);
    check("st_word_rw", snap_rw, 1);
    check("st_word_done_cyc", snap_done_cyc, 3);

    // signed / unsigned byte loads
    run_txn(0, 2'd0, 1, 32'h0000_0013, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    check("ldb_s_be", snap_be, 4'b1000);
    check("ldb_s_rdata", rdata, 32'hFFFF_FF80);
    run_txn(0, 2'd0, 0, 32'h0000_0013, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    check("ldb_u_rdata", rdata, 32'h0000_0080);

    // half store
    run_txn(1, 2'd1, 0, 32'h0000_0022, 32'h0000_1234, 32'h0, 0, 0, 0);
    check("st_half_be", snap_be, 4'b1100);
    check("st_half_mdo", snap_mdo, 32'h1234_1234);

    // byte store lane 3
    run_txn(1, 2'd0, 0, 32'h0000_0003, 32'h0000_00AB, 32'h0, 1, 0, 0);
    check("st_byte_mdo", snap_mdo, 32'hABAB_ABAB);
    check("st_byte_rdata_kept", rdata, 32'h0000_0080);

    // misaligned: word at 0x06, half at odd, reserved size
    run_txn(0, 2'd2, 0, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 0);
    check("mis_cs_count", snap_cs_count, 0);
    check("mis_done_cyc", snap_done_cyc, 1);
    check("mis_aerr", snap_aerr, 1);
    run_txn(0, 2'd1, 0, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 0);
    run_txn(0, 2'd3, 0, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 0);

    // timeout, RData unchanged
    run_txn(0, 2'd2, 0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 1000, 0, 0);
    check("to_done_cyc", snap_done_cyc, 18);
    check("to_terr", snap_terr, 1);
    check("to_rdata_kept", rdata, 32'h0000_0080);

    // late response after 3 WAIT cycles
    run_txn(0, 2'd2, 0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 3, 0, 0);
    check("late_done_cyc", snap_done_cyc, 6);
    check("late_rdata", rdata, 32'hCAFE_F00D);

    // response on the last permitted WAIT cycle
    run_txn(0, 2'd0, 1, 32'h0000_0001, 32'h0, 32'h0000_7F00, TO, 0, 0);
    check("edge_done_cyc", snap_done_cyc, 18);
    check("edge_terr", snap_terr, 0);
    check("edge_rdata", rdata, 32'h0000_007F);

    // signed half load with Req held during RESP (ignored)
    run_txn(0, 2'd1, 1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 1, 0);
    check("ldh_s_rdata", rdata, 32'hFFFF_8001);

    // reset during WAIT, then a normal request
    run_txn(0, 2'd2, 0, 32'h0000_0080, 32'h0, 32'h0, 1000, 0, 4);
    run_txn(0, 2'd2, 0, 32'h0000_0084, 32'h0, 32'h1111_2222, 1, 0, 0);
    check("post_rst_done_cyc", snap_done_cyc, 4);
    check("post_rst_rdata", rdata, 32'h1111_2222);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

CPU-side load/store initiator for the data-memory bus. It accepts one load or store request at a time from the execute stage and converts it into a single memory bus transaction. It generates byte enables and replicates store data onto the correct lanes. For loads it extracts and sign/zero-extends the returned lane, and it reports completion, misalignment and timeout. It connects directly to the data-memory responder's CS/RW/BE/Addr/DataIn/DataOut/DataReady pins.

## Interface
- TIMEOUT, 15, maximum WAIT cycles without DataReady before aborting; range 1..255.
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  request strobe, sampled only in IDLE.
- Wr  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- Sext  in  1  load sign-extend enable; ignored for word and stores.
- Addr  in  32  byte address.
- WData  in  32  store data, right-justified.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- RData  out  32  load result, valid while Done=1; held until the next Done.
- AddrErr  out  1  valid with Done: misaligned or reserved Size, no bus access made.
- TimeoutErr  out  1  valid with Done: DataReady never arrived.
- CS  out  1  memory chip select.
- RW  out  1  memory write enable (1 = write).
- BE  out  4  byte enables, bit k = byte lane k (little-endian).
- MAddr  out  30  word address = Addr[31:2], registered.
- MDataOut  out  32  store data to memory DataIn.
- MDataIn  in  32  memory DataOut.
- DataReady  in  1  memory response valid.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Req=1 with an aligned request: register Wr, Size, Sext, Addr, WData, then go to ISSUE.
  - Req=1 with a misaligned request: go straight to RESP with AddrErr=1. CS is never asserted.
  - Misaligned means any of: half with Addr[0]=1; word with Addr[1:0]≠00; Size=11.
- ISSUE (exactly one cycle): CS=1; RW=stored Wr; BE and MDataOut driven from the registered request; then go to WAIT.
- WAIT: CS=0, and MAddr/BE stay held.
  - DataReady=1: capture the aligned/extended MDataIn into RData (loads only), then go to RESP.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT, go to RESP with TimeoutErr=1; RData is left unchanged.
- RESP: Done=1 for one cycle, then IDLE. A Req in RESP is ignored; a new request is accepted only in IDLE.
- Byte enables:
  - Byte: BE = 1<<Addr[1:0].
  - Half: BE = Addr[1] ? 1100 : 0011.
  - Word: BE = 1111.
- Store data replication:
  - Byte: MDataOut = {4{WData[7:0]}}.
  - Half: MDataOut = {2{WData[15:0]}}.
  - Word: MDataOut = WData.
- Load extraction:
  - Byte: lane = MDataIn[8*Addr[1:0]+:8], extended to 32 bits with bit 7 when Sext=1, else zeros.
  - Half: lane = MDataIn[16*Addr[1]+:16], extended the same way from bit 15.
  - Word: passthrough.
- Stores: RData is not updated.
- AddrErr and TimeoutErr are never both 1. Both are 0 whenever Done=0.

## Timing
- Reset values: state IDLE; Busy, Done, AddrErr, TimeoutErr, CS, RW = 0; BE = 0000; MAddr, MDataOut, RData = 0; wait counter = 0.
- Reset asserted mid-transaction: immediate return to IDLE with CS dropped. No Done is produced for the aborted request.
- Nominal latency with DataReady=1: Req sampled at edge 0; CS high in cycle 1; capture at end of cycle 2; Done in cycle 3.
- Misaligned request: Done one cycle after the Req edge.
- Timeout: Done in cycle TIMEOUT+3 after the Req edge.
- All outputs are registered or decoded from state; no combinational path from MDataIn to the CPU-side outputs.

## Structure
- Package mem_access_pkg holds:
  - Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - State encodings.
  - Function be_gen(size, addr[1:0]).
- Sub-module load_align: combinational lane extraction and sign/zero extension (MDataIn, Size, Addr[1:0], Sext → 32-bit result). Instantiated once; its output is registered in the top level.

## Test plan
- Word store: Addr=0x0000_0010, WData=0xDEAD_BEEF, DataReady=1 → ISSUE cycle has CS=1, RW=1, BE=1111, MAddr=0x4; Done at cycle 3; no errors.
- Signed byte load: Addr=0x13, Sext=1, MDataIn=0x80FF_7F01 → BE=1000; RData=0xFFFF_FF80. Repeat with Sext=0 → RData=0x0000_0080.
- Half store: Addr=0x22, WData=0x0000_1234 → BE=1100, MDataOut=0x1234_1234.
- Misaligned: word load at Addr=0x06 → CS never asserted; Done with AddrErr=1 one cycle after Req.
- Timeout: DataReady held 0 with TIMEOUT=15 → Done with TimeoutErr=1 in cycle 18; RData unchanged. Then DataReady held 0 for 3 WAIT cycles before going high → Done in cycle 6 with the correct data.
- Reset_n pulsed low during WAIT → CS=0, Busy=0 immediately; no Done; the next request completes normally.
